decode_stage: RTL and testbench

- ID stage of the 5-stage 32-bit pipeline; sits between the IF/ID latch and EX.
- Splits the incoming instruction into fields and drives the register-file read indices. Captures the read data into the ID/EX pipeline register.
- Detects load-use hazards against the LW held in its own ID/EX register. On a hazard it stalls fetch for a parameterised number of cycles and inserts bubbles. The extra stall cycles cover the register file not forwarding LW write-back data.
- Honours branch/jump flush from EX.

---
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage: ID stage of the 5-stage 32-bit pipeline.
//
// Splits the IF/ID instruction into fields, drives the register-file read
// indices, and captures decoded fields plus read data into the ID/EX register.
// It detects load-use hazards against a LW held in its own ID/EX register.
// On a hazard it stalls fetch for LOAD_STALL_CYCLES cycles and inserts one
// bubble per stall cycle. The extra cycles exist because the register file
// does not forward LW write-back data. A flush from EX kills the ID contents.
//
// Handshake: there is no ready/valid back-pressure from EX. inValid qualifies
// inInstr in the same cycle. outValid qualifies every out* field. stallOut
// tells IF to hold the PC and IF/ID, so the same instruction is presented
// again next cycle.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   inValid/inInstr/inPc IF/ID contents (inPc = PC+4 of inInstr)
//   flush                EX redirect; turns this cycle into a bubble
//   rfRdIndex1/2         register-file read indices (combinational)
//   rfData1/2            register-file read data (same cycle)
//   stallOut             hold PC and IF/ID (combinational)
//   out*                 ID/EX pipeline register
//   dbg_state            1 while the FSM is in STALL
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int LOAD_STALL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [31:0] inInstr,
    input  logic [31:0] inPc,
    input  logic        flush,
    output logic [3:0]  rfRdIndex1,
    output logic [3:0]  rfRdIndex2,
    input  logic [31:0] rfData1,
    input  logic [31:0] rfData2,
    output logic        stallOut,
    output logic        outValid,
    output logic [3:0]  outFstOpcode,
    output logic [3:0]  outSecOpcode,
    output logic        outWrtEn,
    output logic [3:0]  outWrtIndex,
    output logic [31:0] outData1,
    output logic [31:0] outData2,
    output logic [31:0] outImm,
    output logic [31:0] outPc,
    output logic        dbg_state
);

    localparam logic [3:0] OP1_ALUR  = 4'h0;
    localparam logic [3:0] OP1_BCOND = 4'h2;
    localparam logic [3:0] OP1_SW    = 4'h5;
    localparam logic [3:0] OP1_ALUI  = 4'h8;
    localparam logic [3:0] OP1_LW    = 4'h9;
    localparam logic [3:0] OP1_JAL   = 4'hB;

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t     state, next_state;
    logic [2:0] cnt, next_cnt;

    logic [3:0]  fst_opcode, sec_opcode, rd, rs1, rs2;
    logic [15:0] imm;
    logic        uses_rs1, uses_rs2, writes_rd, hazard;
    logic        stall, load_bubble, load_instr;

    assign fst_opcode = inInstr[31:28];
    assign sec_opcode = inInstr[27:24];
    assign rd         = inInstr[23:20];
    assign rs1        = inInstr[19:16];
    assign rs2        = inInstr[15:12];
    assign imm        = inInstr[15:0];

    assign rfRdIndex1 = rs1;
    assign rfRdIndex2 = rs2;
    assign dbg_state  = (state == STALL);

    // Unknown opcodes decode as NOPs: no reads, no write-back.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (fst_opcode)
            OP1_ALUR:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP1_BCOND: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP1_SW:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP1_ALUI:  begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP1_LW:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP1_JAL:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            default:   ;
        endcase
    end

    // Only a LW in ID/EX is a hazard. Other producers are bypassed in EX.
    assign hazard = outValid && (outFstOpcode == OP1_LW) && outWrtEn && inValid &&
                    ((uses_rs1 && (rs1 == outWrtIndex)) ||
                     (uses_rs2 && (rs2 == outWrtIndex)));

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        stall       = 1'b0;
        load_bubble = 1'b0;
        load_instr  = 1'b0;
        if (flush) begin
            // A redirect overrides both a new hazard and a stall in progress.
            load_bubble = 1'b1;
            next_state  = IDLE;
            next_cnt    = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        stall       = 1'b1;
                        load_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_cnt   = 3'(LOAD_STALL_CYCLES - 1);
                            next_state = STALL;
                        end
                    end else begin
                        load_instr = 1'b1;
                    end
                end
                STALL: begin
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    next_cnt    = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = 3'd0;
                end
            endcase
        end
    end

    assign stallOut = stall && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Bubbles only clear the control fields. The data fields are don't-care
    // while outValid is 0, so they keep their previous values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid     <= 1'b0;
            outFstOpcode <= 4'h0;
            outSecOpcode <= 4'h0;
            outWrtEn     <= 1'b0;
            outWrtIndex  <= 4'h0;
            outData1     <= 32'h0;
            outData2     <= 32'h0;
            outImm       <= 32'h0;
            outPc        <= 32'h0;
        end else if (load_bubble) begin
            outValid     <= 1'b0;
            outWrtEn     <= 1'b0;
            outFstOpcode <= 4'h0;
        end else if (load_instr) begin
            outValid     <= inValid;
            outFstOpcode <= fst_opcode;
            outSecOpcode <= sec_opcode;
            outWrtEn     <= inValid && writes_rd;
            outWrtIndex  <= rd;
            outData1     <= rfData1;
            outData2     <= rfData2;
            outImm       <= {{16{imm[15]}}, imm};
            outPc        <= inPc;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage: self-checking bench for decode_stage.
// Directed scenarios first, then randomized traffic. Everything is checked
// against a cycle-level reference model of the ID/EX register and of the
// number of bubbles still owed to a load-use hazard.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam int N = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        inValid = 1'b0;
    logic [31:0] inInstr = 32'h0;
    logic [31:0] inPc = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] rfData1 = 32'h0;
    logic [31:0] rfData2 = 32'h0;
    logic [3:0]  rfRdIndex1, rfRdIndex2;
    logic        stallOut, outValid, outWrtEn, dbg_state;
    logic [3:0]  outFstOpcode, outSecOpcode, outWrtIndex;
    logic [31:0] outData1, outData2, outImm, outPc;

    decode_stage #(.LOAD_STALL_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inInstr(inInstr),
        .inPc(inPc), .flush(flush), .rfRdIndex1(rfRdIndex1),
        .rfRdIndex2(rfRdIndex2), .rfData1(rfData1), .rfData2(rfData2),
        .stallOut(stallOut), .outValid(outValid), .outFstOpcode(outFstOpcode),
        .outSecOpcode(outSecOpcode), .outWrtEn(outWrtEn),
        .outWrtIndex(outWrtIndex), .outData1(outData1), .outData2(outData2),
        .outImm(outImm), .outPc(outPc), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_valid, m_we;
    logic [3:0]  m_op, m_sec, m_wi;
    logic [31:0] m_d1, m_d2, m_imm, m_pc;
    int          pend;          // bubbles still owed to the current hazard
    logic        exp_stall;
    int          stall_cnt;     // cycles with stallOut expected high

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [15:0] imm);
        return {op, 4'h3, rd, rs1, imm};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_op = 0; m_sec = 0; m_wi = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; pend = 0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, ".valid"}, 32'(outValid), 32'(m_valid));
        check({pfx, ".op"},    32'(outFstOpcode), 32'(m_op));
        check({pfx, ".sec"},   32'(outSecOpcode), 32'(m_sec));
        check({pfx, ".we"},    32'(outWrtEn), 32'(m_we));
        check({pfx, ".wi"},    32'(outWrtIndex), 32'(m_wi));
        check({pfx, ".d1"},    outData1, m_d1);
        check({pfx, ".d2"},    outData2, m_d2);
        check({pfx, ".imm"},   outImm, m_imm);
        check({pfx, ".pc"},    outPc, m_pc);
        check({pfx, ".state"}, 32'(dbg_state), 32'(pend > 0));
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model, clock, then check the ID/EX register.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl);
        logic [3:0] op, rs1, rs2;
        logic u1, u2, wr, hz;
        inValid = v; inInstr = ins; flush = fl;
        inPc = $urandom; rfData1 = $urandom; rfData2 = $urandom;
        n_vec++;
        #1;
        op = ins[31:28]; rs1 = ins[19:16]; rs2 = ins[15:12];
        u1 = op inside {4'h0, 4'h2, 4'h5, 4'h8, 4'h9, 4'hB};
        u2 = op inside {4'h0, 4'h2, 4'h5};
        wr = op inside {4'h0, 4'h8, 4'h9, 4'hB};
        hz = m_valid && m_op == 4'h9 && m_we && v &&
             ((u1 && rs1 == m_wi) || (u2 && rs2 == m_wi));
        check("rd_index1", 32'(rfRdIndex1), 32'(rs1));
        check("rd_index2", 32'(rfRdIndex2), 32'(rs2));
        if (fl) begin
            exp_stall = 0; pend = 0;
        end else if (pend > 0) begin
            exp_stall = 1; pend--;
        end else if (hz) begin
            exp_stall = 1; pend = N - 1;
        end else begin
            exp_stall = 0;
        end
        check("stall", 32'(stallOut), 32'(exp_stall));
        if (exp_stall) stall_cnt++;
        if (fl || exp_stall) begin
            m_valid = 0; m_we = 0; m_op = 0;
        end else begin
            m_valid = v; m_op = op; m_sec = ins[27:24]; m_we = v && wr;
            m_wi = ins[23:20]; m_d1 = rfData1; m_d2 = rfData2;
            m_imm = {{16{ins[15]}}, ins[15:0]}; m_pc = inPc;
        end
        @(posedge clk);
        #1;
        check_regs("idex");
    endtask

    logic [3:0] ops[8] = '{4'h0, 4'h2, 4'h5, 4'h8, 4'h9, 4'h9, 4'hB, 4'hF};

    initial begin
        logic [31:0] cur;
        logic        cur_v;
        model_reset();
        exp_stall = 0;
        stall_cnt = 0;
        #2;
        check_regs("reset");
        check("reset.stall", 32'(stallOut), 32'd0);
        #20 reset = 1'b0;

        // Simple issue with known data.
        inValid = 1; inInstr = {4'h0, 4'h1, 4'd3, 4'd1, 4'd2, 12'h0}; flush = 0;
        rfData1 = 32'd5; rfData2 = 32'd7; inPc = 32'h104;
        #1;
        check("issue.stall", 32'(stallOut), 32'd0);
        @(posedge clk); #1;
        check("issue.valid", 32'(outValid), 32'd1);
        check("issue.we", 32'(outWrtEn), 32'd1);
        check("issue.wi", 32'(outWrtIndex), 32'd3);
        check("issue.d1", outData1, 32'd5);
        check("issue.d2", outData2, 32'd7);
        m_valid = 1; m_op = 0; m_sec = 1; m_we = 1; m_wi = 3; m_d1 = 5; m_d2 = 7;
        m_imm = 32'h2000; m_pc = 32'h104;

        // Sign extension.
        step(1, mk(4'h8, 4'd1, 4'd2, 16'hFFFC), 0);
        check("imm.neg", outImm, 32'hFFFF_FFFC);
        step(1, mk(4'h8, 4'd1, 4'd2, 16'h0010), 0);
        check("imm.pos", outImm, 32'h0000_0010);

        // Load-use via rs2: exactly N stalls, then issue.
        stall_cnt = 0;
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        for (int i = 0; i < N; i++) begin
            step(1, mk(4'h0, 4'd6, 4'd1, 16'h4000), 0);
            check("lu_rs2.bubble", 32'(outValid), 32'd0);
        end
        step(1, mk(4'h0, 4'd6, 4'd1, 16'h4000), 0);
        check("lu_rs2.issue", 32'(outValid), 32'd1);
        check("lu_rs2.count", 32'(stall_cnt), 32'(N));

        // Load-use via rs1 of ALUI.
        stall_cnt = 0;
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        for (int i = 0; i <= N; i++) step(1, mk(4'h8, 4'd6, 4'd4, 16'h0), 0);
        check("lu_rs1.issue", 32'(outValid), 32'd1);
        check("lu_rs1.count", 32'(stall_cnt), 32'(N));

        // No false hazards; SW through rs2 does stall.
        stall_cnt = 0;
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        step(1, mk(4'h8, 4'd6, 4'd5, 16'h4000), 0);
        step(1, mk(4'h0, 4'd4, 4'd0, 16'h0), 0);
        step(1, mk(4'h0, 4'd6, 4'd4, 16'h0), 0);
        check("no_false.count", 32'(stall_cnt), 32'd0);
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        for (int i = 0; i <= N; i++) step(1, mk(4'h5, 4'd0, 4'd1, 16'h4000), 0);
        check("sw.count", 32'(stall_cnt), 32'(N));

        // Flush in first STALL cycle, and flush without hazard.
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        step(1, mk(4'h0, 4'd6, 4'd4, 16'h0), 0);
        step(1, mk(4'h0, 4'd6, 4'd4, 16'h0), 1);
        check("flush.state", 32'(dbg_state), 32'd0);
        step(1, mk(4'h0, 4'd6, 4'd1, 16'h2000), 1);
        check("flush.bubble", 32'(outValid), 32'd0);

        // Reset in the middle of a stall.
        step(1, mk(4'h9, 4'd4, 4'd0, 16'h0), 0);
        step(1, mk(4'h0, 4'd6, 4'd4, 16'h0), 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_regs("rst_mid");
        check("rst_mid.stall", 32'(stallOut), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1, mk(4'h0, 4'd6, 4'd4, 16'h0), 0);
        check("rst_mid.issue", 32'(outValid), 32'd1);

        // Randomized traffic; IF/ID holds its contents while stalled.
        cur = mk(4'h0, 4'd1, 4'd2, 16'h3000);
        cur_v = 1;
        for (int i = 0; i < 400; i++) begin
            if (!exp_stall) begin
                cur = {ops[$urandom_range(7)], 4'($urandom), 4'($urandom_range(3)),
                       4'($urandom_range(3)), 2'b00, 2'($urandom_range(3)), 12'($urandom)};
                cur_v = ($urandom_range(9) != 0);
            end
            step(cur_v, cur, $urandom_range(99) < 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
